// File: rtl/multi_cycle_proccessor.sv
// 32-bit MIPS-subset multi-cycle core with unified memory, EPC/ISF interrupt
// support (level INT gated by INTD, edge-latched NMI with priority).
module multi_cycle_proccessor (
    input  logic clk,
    input  logic reset,
    input  logic INT,
    input  logic NMI,
    input  logic INTD,
    output logic INA
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ERET  = 6'h10;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_ERET  = 6'h18;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC,
        RWB, IWB, BRANCH, JUMP, ERET, INTACK
    } state_t;

    state_t state, next;

    logic [31:0] pc, ir, mdr, a, b, aluout, epc;
    logic        isf, nmi_q, nmi_lat, nmi_sel;
    logic [31:0] mem [0:255];
    logic [31:0] rf  [0:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext, rs_val, rt_val, alu_res;
    logic        r_ok, nmi_edge, pending;
    state_t      done_state;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    assign rs_val = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf[rt];

    assign r_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                  (funct == FN_OR)  || (funct == FN_SLT);

    assign nmi_edge = NMI & ~nmi_q;
    // Interrupts are only considered where an instruction finishes; ISF masks both sources.
    assign pending    = ~isf & (nmi_lat | (INT & ~INTD));
    assign done_state = pending ? INTACK : FETCH;

    always_comb begin
        alu_res = a + b;
        if (op == OP_ADDI) begin
            alu_res = a + sext;
        end else begin
            case (funct)
                FN_SUB:  alu_res = a - b;
                FN_AND:  alu_res = a & b;
                FN_OR:   alu_res = a | b;
                FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = a + b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            FETCH:   next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next = MEMADDR;
                    OP_RTYPE:     next = r_ok ? EXEC : done_state;
                    OP_ADDI:      next = EXEC;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ERET:      next = (funct == FN_ERET) ? ERET : done_state;
                    default:      next = done_state;
                endcase
            end
            MEMADDR: next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next = MEMWB;
            EXEC:    next = (op == OP_RTYPE) ? RWB : IWB;
            MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP, ERET: next = done_state;
            INTACK:  next = FETCH;
            default: next = FETCH;
        endcase
    end

    always_comb begin
        INA = (state == INTACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            aluout  <= '0;
            epc     <= '0;
            isf     <= 1'b0;
            nmi_q   <= 1'b0;
            nmi_lat <= 1'b0;
            nmi_sel <= 1'b0;
        end else begin
            nmi_q <= NMI;
            // An edge landing in INTACK re-arms the latch after the serviced NMI clears it.
            if (state == INTACK && nmi_sel) nmi_lat <= nmi_edge;
            else if (nmi_edge)              nmi_lat <= 1'b1;
            if (state != INTACK) nmi_sel <= nmi_lat;

            case (state)
                FETCH: begin
                    ir <= mem[pc[9:2]];
                    pc <= pc + 32'd4;
                end
                DECODE: begin
                    a      <= rs_val;
                    b      <= rt_val;
                    aluout <= pc + {sext[29:0], 2'b00};
                end
                MEMADDR: aluout <= a + sext;
                MEMRD:   mdr <= mem[aluout[9:2]];
                EXEC:    aluout <= alu_res;
                BRANCH:  if (a == b) pc <= aluout;
                JUMP:    pc <= {pc[31:28], ir[25:0], 2'b00};
                ERET: begin
                    pc  <= epc;
                    isf <= 1'b0;
                end
                INTACK: begin
                    epc <= pc;
                    isf <= 1'b1;
                    pc  <= nmi_sel ? 32'h0000_0080 : 32'h0000_0040;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                MEMWB: if (rt != 5'd0) rf[rt] <= mdr;
                RWB:   if (rd != 5'd0) rf[rd] <= aluout;
                IWB:   if (rt != 5'd0) rf[rt] <= aluout;
                default: ;
            endcase
        end
    end

    // Memory contents survive reset; only the store state writes.
    always_ff @(posedge clk) begin
        if (!reset && state == MEMWR) mem[aluout[9:2]] <= b;
    end
endmodule

// File: tb/tb_multi_cycle_proccessor.sv
// Directed bench for multi_cycle_proccessor: ALU vector table plus hand-written
// load/store, branch, reset and interrupt sequences.
module tb_multi_cycle_proccessor;
    logic clk = 1'b0;
    logic reset, INT, NMI, INTD;
    logic INA;

    int checks = 0;
    int failures = 0;
    int ina_cnt = 0;
    int s;

    localparam logic [31:0] ERET_W = {6'h10, 20'h0, 6'h18};

    typedef struct {
        logic [5:0]  fn;
        logic [4:0]  rd;
        logic [15:0] ia;
        logic [15:0] ib;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [9];

    multi_cycle_proccessor dut (
        .clk(clk), .reset(reset), .INT(INT), .NMI(NMI), .INTD(INTD), .INA(INA)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (INA === 1'b1) ina_cnt++;

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic begin_test();
        @(negedge clk);
        reset = 1'b1;
        INT = 1'b0;
        NMI = 1'b0;
        INTD = 1'b0;
        for (int i = 0; i < 256; i++) dut.mem[i] = '0;
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_ina(input int budget, input string name);
        int n;
        n = 0;
        while (INA !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, INA}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{6'h20, 5'd3, 16'd5,    16'd7,    32'd12};
        vecs[1] = '{6'h22, 5'd3, 16'd5,    16'd7,    32'hFFFF_FFFE};
        vecs[2] = '{6'h24, 5'd5, 16'h0FF0, 16'h00FF, 32'h0000_00F0};
        vecs[3] = '{6'h25, 5'd6, 16'h0FF0, 16'h00FF, 32'h0000_0FFF};
        vecs[4] = '{6'h2A, 5'd7, 16'hFFFF, 16'h0001, 32'd1};
        vecs[5] = '{6'h2A, 5'd7, 16'h0001, 16'hFFFF, 32'd0};
        vecs[6] = '{6'h20, 5'd8, 16'hFFFD, 16'h7FFF, 32'h0000_7FFC};
        vecs[7] = '{6'h22, 5'd9, 16'h8000, 16'h7FFF, 32'hFFFF_0001};
        vecs[8] = '{6'h20, 5'd0, 16'd5,    16'd7,    32'd0};

        // Four-instruction store program: 16 cycles, no interrupts.
        begin_test();
        dut.mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        dut.mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
        dut.mem[2] = r_ins(6'h20, 5'd1, 5'd2, 5'd3);
        dut.mem[3] = i_ins(6'h2B, 5'd0, 5'd3, 16'h0020);
        end_reset();
        check("reset_pc", dut.pc, 32'd0);
        check("reset_state", 32'(dut.state), 32'd0);
        s = ina_cnt;
        tick(15);
        check("sw_before_last_cycle", dut.mem[8], 32'd0);
        tick(1);
        check("sw_mem8", dut.mem[8], 32'd12);
        check("sw_rf3", dut.rf[3], 32'd12);
        check("sw_next_pc", dut.pc, 32'h10);
        check("sw_no_ina", 32'(ina_cnt - s), 32'd0);

        // Reset after a run: registers cleared, memory kept.
        reset = 1'b1;
        tick(2);
        check("rst_pc", dut.pc, 32'd0);
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_ina", {31'd0, INA}, 32'd0);
        check("rst_rf3", dut.rf[3], 32'd0);
        check("rst_ir", dut.ir, 32'd0);
        check("rst_aluout", dut.aluout, 32'd0);
        check("rst_keeps_mem", dut.mem[8], 32'd12);
        reset = 1'b0;

        for (int k = 0; k < 9; k++) begin
            begin_test();
            dut.mem[0] = i_ins(6'h08, 5'd0, 5'd1, vecs[k].ia);
            dut.mem[1] = i_ins(6'h08, 5'd0, 5'd2, vecs[k].ib);
            dut.mem[2] = r_ins(vecs[k].fn, 5'd1, 5'd2, vecs[k].rd);
            dut.mem[3] = j_ins(26'd3);
            end_reset();
            tick(12);
            check($sformatf("alu_vec%0d", k), dut.rf[vecs[k].rd], vecs[k].exp);
        end

        // lw: 5-cycle latency.
        begin_test();
        dut.mem[0] = i_ins(6'h23, 5'd0, 5'd4, 16'h0020);
        dut.mem[8] = 32'hDEAD_BEEF;
        end_reset();
        tick(4);
        check("lw_before_wb", dut.rf[4], 32'd0);
        tick(1);
        check("lw_rf4", dut.rf[4], 32'hDEAD_BEEF);

        // beq not taken, beq taken, then j.
        begin_test();
        dut.mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
        dut.mem[1] = i_ins(6'h04, 5'd0, 5'd1, 16'd5);
        dut.mem[2] = i_ins(6'h04, 5'd0, 5'd0, 16'd2);
        dut.mem[5] = j_ins(26'h10);
        end_reset();
        tick(7);
        check("beq_not_taken_pc", dut.pc, 32'h08);
        tick(3);
        check("beq_taken_pc", dut.pc, 32'h14);
        tick(3);
        check("j_pc", dut.pc, 32'h40);
        check("j_state_fetch", 32'(dut.state), 32'd0);

        // Reset in the store's write cycle must suppress the write.
        begin_test();
        dut.mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'h0055);
        dut.mem[1] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0024);
        end_reset();
        tick(7);
        check("abort_in_memwr", 32'(dut.state), 32'd5);
        check("abort_rf1_pre", dut.rf[1], 32'h55);
        reset = 1'b1;
        tick(1);
        check("abort_no_write", dut.mem[9], 32'd0);
        check("abort_rf_cleared", dut.rf[1], 32'd0);
        reset = 1'b0;

        // INT during instruction at 0x04, then eret back.
        begin_test();
        dut.mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
        dut.mem[1]  = i_ins(6'h08, 5'd0, 5'd2, 16'd2);
        dut.mem[16] = ERET_W;
        end_reset();
        s = ina_cnt;
        tick(5);
        INT = 1'b1;
        wait_ina(8, "int_ack_seen");
        INT = 1'b0;
        tick(1);
        check("int_vector_pc", dut.pc, 32'h40);
        check("int_epc", dut.epc, 32'h08);
        check("int_isf", {31'd0, dut.isf}, 32'd1);
        check("int_insn_done", dut.rf[2], 32'd2);
        check("int_one_pulse", 32'(ina_cnt - s), 32'd1);
        tick(3);
        check("eret_pc", dut.pc, 32'h08);
        check("eret_isf", {31'd0, dut.isf}, 32'd0);

        // INTD masks INT but not NMI.
        begin_test();
        INTD = 1'b1;
        INT = 1'b1;
        end_reset();
        s = ina_cnt;
        tick(10);
        check("intd_no_ina", 32'(ina_cnt - s), 32'd0);
        check("intd_pc", dut.pc, 32'h14);
        NMI = 1'b1;
        tick(1);
        NMI = 1'b0;
        wait_ina(6, "nmi_ack_seen");
        tick(1);
        check("nmi_vector_pc", dut.pc, 32'h80);
        check("nmi_epc", dut.epc, 32'h18);
        check("nmi_one_pulse", 32'(ina_cnt - s), 32'd1);

        // INT and NMI together: NMI first, INT held off until eret.
        begin_test();
        dut.mem[33] = ERET_W;
        end_reset();
        INT = 1'b1;
        NMI = 1'b1;
        s = ina_cnt;
        tick(1);
        NMI = 1'b0;
        wait_ina(4, "both_ack_seen");
        tick(1);
        check("both_nmi_first", dut.pc, 32'h80);
        check("both_epc", dut.epc, 32'h04);
        tick(5);
        check("isf_blocks_int", 32'(ina_cnt - s), 32'd1);
        check("both_eret_pc", dut.pc, 32'h04);
        wait_ina(4, "int_after_eret_seen");
        tick(1);
        check("int_after_eret_pc", dut.pc, 32'h40);
        check("int_after_eret_epc", dut.epc, 32'h08);
        check("two_pulses", 32'(ina_cnt - s), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_cycle_proccessor.md
MULTI_CYCLE_PROCCESSOR -- requirements
Module: multi_cycle_proccessor

Interface
REQ-001 The block SHALL have clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 The block SHALL have INT, input, 1 bit: maskable interrupt request, level-sensitive.
REQ-004 The block SHALL have NMI, input, 1 bit: non-maskable interrupt request, rising-edge detected.
REQ-005 The block SHALL have INTD, input, 1 bit: interrupt disable; while 1, INT is ignored and NMI is not.
REQ-006 The block SHALL have INA, output, 1 bit: interrupt acknowledge, high for exactly one cycle per accepted interrupt.

Function
REQ-007 The block SHALL be a 32-bit MIPS-subset multi-cycle core with PC, IR, MDR, A, B, ALUOut, EPC and an in-service flag (ISF).
REQ-008 The block SHALL contain one unified 256x32 memory, word-indexed by address[9:2], with asynchronous read and synchronous write; address bits [1:0] SHALL be ignored.
REQ-009 The block SHALL contain a 32x32 register file; reads of $0 SHALL return 0 and writes to $0 SHALL be discarded.
REQ-010 The block SHALL support these instructions: R-type add/sub/and/or/slt (op 0x00), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02, eret 0x10/funct 0x18.
REQ-011 The block SHALL treat any other opcode as a NOP that returns to FETCH after DECODE.
REQ-012 The control FSM SHALL have states FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR, EXEC, RWB, IWB, BRANCH, JUMP, ERET, INTACK.
REQ-013 FETCH: IR<=mem[PC], PC<=PC+4, next state DECODE.
REQ-014 DECODE: A,B<=rs,rt and ALUOut<=PC+(sext(imm)<<2); dispatch by opcode.
REQ-015 Latencies SHALL be: lw 5 cycles, sw/R-type/addi 4 cycles, beq/j/eret 3 cycles.
REQ-016 beq SHALL set PC<=ALUOut when A==B; j SHALL set PC<={PC[31:28],target,2'b00}.
REQ-017 Arithmetic SHALL be 32-bit wrap-around with no overflow trap; slt SHALL be a signed compare; addi SHALL sign-extend its immediate.
REQ-018 eret SHALL set PC<=EPC and clear ISF.
REQ-019 Interrupts SHALL be sampled only on the cycle an instruction's last state completes, i.e. at the instruction boundary before FETCH.
REQ-020 The pending condition SHALL be: (NMI edge latched) OR (INT & ~INTD); any pending interrupt SHALL be blocked while ISF=1.
REQ-021 If both sources are pending, NMI SHALL take priority; the latched NMI edge SHALL be held until it is serviced.
REQ-022 On acceptance the FSM SHALL enter INTACK for one cycle: INA=1, EPC<=PC (the next instruction's address), ISF<=1, and PC<=0x00000080 for NMI or 0x00000040 for INT; the NMI latch SHALL clear; next state FETCH.
REQ-023 A NMI edge arriving during INTACK SHALL be latched again and serviced after eret.

Reset
REQ-024 When reset=1 at a clock edge: PC=0, state=FETCH, INA=0, EPC=0, ISF=0, NMI latch and edge-detect register 0, IR/A/B/ALUOut/MDR=0.
REQ-025 Reset SHALL clear all registers in the register file.
REQ-026 Reset SHALL NOT alter memory contents.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction with no register or memory write on that edge.

Verification
REQ-028 Preload addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x20($0) -> mem[8]=12 after 16 cycles, INA stays 0.
REQ-029 Preload lw $4,0x20($0) with mem[8]=0xDEADBEEF -> $4=0xDEADBEEF after 5 cycles.
REQ-030 beq $0,$0,+2 at PC 0 -> next fetch at PC 0x0C; j 0x10 -> next fetch at 0x40.
REQ-031 INT=1, INTD=0 during the instruction at 0x04 -> INA pulses one cycle, EPC=0x08, next fetch at 0x40; eret at 0x40 -> next fetch at 0x08.
REQ-032 INT=1 with INTD=1 -> no INA; NMI pulse for one cycle with INTD=1 -> INA pulse, next fetch at 0x80.
REQ-033 INT and NMI both pending -> NMI vector 0x80 taken first; a second INT while ISF=1 -> ignored until eret.
